// File: rtl/if_prefetch_buf.sv
// if_prefetch_buf
// Instruction prefetch unit feeding the IF/ID register. Issues sequential
// word-address fetches over a req/ack handshake (one outstanding at most),
// buffers returned {pc, insn} pairs in a DEPTH-entry FIFO and presents the
// head to decode over valid/ready. A taken branch flushes the buffer and
// redirects fetch.
//
// Optional build macro: IF_PREFETCH_BYPASS_EN
//   defined   : an ack arriving while the FIFO is empty is shown on
//               if_pc/if_insn in the same cycle; consumed directly if
//               if_ready=1, otherwise pushed as normal.
//   undefined : outputs are purely registered (ack -> if_valid next cycle).
//
// Ports
//   clk, reset          clock (rising edge), async active-low reset
//   cpu_en              allow new fetch requests
//   br_taken, br_addr   redirect from decode
//   imem_req/addr       fetch request, address stable while req=1
//   imem_ack/rd_data    fetch completion and returned instruction
//   if_valid/ready      head handshake to decode
//   if_pc, if_insn      head entry (hold last value when empty)
//   fifo_count          occupied entries
//
// state | meaning
// IDLE  | no request outstanding
// REQ   | request outstanding, data will be buffered
// DROP  | request outstanding but redirected; data will be discarded
module if_prefetch_buf #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 30,
  parameter int                INSN_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_en,
  input  logic                       br_taken,
  input  logic [ADDR_W-1:0]          br_addr,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_ack,
  input  logic [INSN_W-1:0]          imem_rd_data,
  output logic                       if_valid,
  input  logic                       if_ready,
  output logic [ADDR_W-1:0]          if_pc,
  output logic [INSN_W-1:0]          if_insn,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]     CNT_ONE = CW'(1);
  localparam logic [PW-1:0]     PTR_ONE = PW'(1);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
`ifdef IF_PREFETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t            state;
  logic              req_q;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] out_pc;
  logic [INSN_W-1:0] out_insn;
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INSN_W-1:0] insn_mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;

  logic ack_ok;
  logic fifo_pop;
  logic bypass;
  logic bypass_take;
  logic push;

  assign ack_ok      = (state == REQ) && imem_ack && !br_taken;
  assign fifo_pop    = (count != '0) && if_ready && !br_taken;
  assign bypass      = BYPASS && (count == '0) && ack_ok;
  assign bypass_take = bypass && if_ready;
  assign push        = ack_ok && !bypass_take;

  always_comb begin
    count_next = count;
    if (push && !fifo_pop)      count_next = count + CNT_ONE;
    else if (!push && fifo_pop) count_next = count - CNT_ONE;
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign fifo_count = count;
  assign if_valid   = (count != '0) || bypass;
  assign if_pc      = bypass ? addr_q : out_pc;
  assign if_insn    = bypass ? imem_rd_data : out_insn;

  // Fetch FSM and fetch pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_en && (count < DEPTH_C) && !br_taken) begin
            state  <= REQ;
            req_q  <= 1'b1;
            addr_q <= fetch_pc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if (br_taken) begin
              state <= IDLE;
              req_q <= 1'b0;
            end else begin
              fetch_pc <= fetch_pc + PC_ONE;
              // Back-to-back only if the new request still has a slot
              // after this cycle's push/pop settle.
              if (cpu_en && (count_next < DEPTH_C)) begin
                addr_q <= fetch_pc + PC_ONE;
              end else begin
                state <= IDLE;
                req_q <= 1'b0;
              end
            end
          end else if (br_taken) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
      if (br_taken) fetch_pc <= br_addr;
    end
  end

  // FIFO pointers, occupancy and head-output registers. The head is kept
  // in its own register so it holds its last value once the FIFO drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      out_pc   <= '0;
      out_insn <= '0;
    end else if (br_taken) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PTR_ONE;
      if (fifo_pop) rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      if (ack_ok && ((count == '0) || (fifo_pop && (count == CNT_ONE)))) begin
        out_pc   <= addr_q;
        out_insn <= imem_rd_data;
      end else if (fifo_pop && (count > CNT_ONE)) begin
        out_pc   <= pc_mem[rd_ptr + PTR_ONE];
        out_insn <= insn_mem[rd_ptr + PTR_ONE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !br_taken) begin
      pc_mem[wr_ptr]   <= addr_q;
      insn_mem[wr_ptr] <= imem_rd_data;
    end
  end

endmodule

// File: tb/tb_if_prefetch_buf.sv
module tb_if_prefetch_buf;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [29:0] RESET_PC = 30'h0;
`ifdef IF_PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] insn;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_en;
  logic          br_taken;
  logic [29:0]   br_addr;
  logic          imem_req;
  logic [29:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rd_data;
  logic          if_valid;
  logic          if_ready;
  logic [29:0]   if_pc;
  logic [31:0]   if_insn;
  logic [CW-1:0] fifo_count;

  if_prefetch_buf #(.DEPTH(DEPTH), .ADDR_W(30), .INSN_W(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .br_taken(br_taken), .br_addr(br_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rd_data(imem_rd_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_insn(if_insn), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus controls, written by the main sequence at posedge and applied
  // by the driver at negedge.
  bit          rand_on = 1'b0;
  int          minw = 0;
  int          maxw = 0;
  logic        dir_cpu_en = 1'b0;
  logic        dir_ready = 1'b0;
  logic        dir_br = 1'b0;
  logic [29:0] dir_br_addr = '0;
  int          mem_wait = -1;

  // Driver: control inputs plus a memory with random ack latency.
  initial begin
    cpu_en = 1'b0; if_ready = 1'b0; br_taken = 1'b0; br_addr = '0;
    imem_ack = 1'b0; imem_rd_data = '0;
    forever begin
      @(negedge clk);
      if (rand_on) begin
        cpu_en   = ($urandom_range(9, 0) != 0);
        if_ready = ($urandom_range(9, 0) < 7);
        br_taken = ($urandom_range(24, 0) == 0);
        br_addr  = ($urandom_range(7, 0) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
      end else begin
        cpu_en   = dir_cpu_en;
        if_ready = dir_ready;
        br_taken = dir_br;
        br_addr  = dir_br_addr;
        dir_br   = 1'b0;
      end
      imem_ack = 1'b0;
      if (imem_req && reset) begin
        if (mem_wait < 0) mem_wait = int'($urandom_range(maxw, minw));
        if (mem_wait == 0) begin
          imem_ack     = 1'b1;
          imem_rd_data = {2'b00, imem_addr} ^ 32'hA5A5_0000 ^ {16'h0, 16'($urandom)};
          mem_wait     = -1;
        end else begin
          mem_wait--;
        end
      end else begin
        mem_wait = -1;
      end
    end
  end

  // Reference model: decode sees consecutive pcs from the last redirect;
  // an ack belongs to a stale request if a redirect hit while it was pending.
  ent_t        sb[$];
  logic [29:0] exp_fetch = RESET_PC;
  bit          stale = 1'b0;
  bit          prev_pend = 1'b0;
  logic [29:0] prev_addr = '0;
  int          ack_count = 0;
  logic [29:0] popped[$];

  always begin
    ent_t e;
    bit   consumed;
    bit   exp_valid;
    @(negedge clk); #1;
    if (!reset) begin
      sb.delete();
      exp_fetch = RESET_PC;
      stale     = 1'b0;
      prev_pend = 1'b0;
    end else begin
      consumed  = 1'b0;
      exp_valid = (sb.size() != 0) || (BYP && imem_req && imem_ack && !br_taken && !stale);
      check("fifo_count", 64'(fifo_count), 64'(sb.size()));
      check("if_valid", 64'(if_valid), 64'(exp_valid));
      check("slot_rule", 64'((sb.size() + int'(imem_req)) <= DEPTH), 64'(1));
      if (prev_pend) begin
        check("req_held", 64'(imem_req), 64'(1));
        check("addr_held", 64'(imem_addr), 64'(prev_addr));
      end
      prev_pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
      if (br_taken) begin
        if (imem_req && !imem_ack) stale = 1'b1;
        else if (imem_ack) stale = 1'b0;
        sb.delete();
        exp_fetch = br_addr;
      end else begin
        if (if_valid && if_ready) begin
          if (sb.size() > 0) begin
            e = sb.pop_front();
          end else begin
            e.pc   = imem_addr;
            e.insn = imem_rd_data;
            consumed = 1'b1;
            check("bypass_legal", 64'(BYP && imem_ack && !stale), 64'(1));
          end
          check("if_pc", 64'(if_pc), 64'(e.pc));
          check("if_insn", 64'(if_insn), 64'(e.insn));
          popped.push_back(if_pc);
        end
        if (imem_req && imem_ack) begin
          if (stale) begin
            stale = 1'b0;
          end else begin
            check("imem_addr", 64'(imem_addr), 64'(exp_fetch));
            exp_fetch = exp_fetch + 30'd1;
            ack_count++;
            if (!consumed) sb.push_back('{pc: imem_addr, insn: imem_rd_data});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b0;
    #7;
    check("rst_imem_req", 64'(imem_req), 64'(0));
    check("rst_imem_addr", 64'(imem_addr), 64'(RESET_PC));
    check("rst_if_valid", 64'(if_valid), 64'(0));
    check("rst_fifo_count", 64'(fifo_count), 64'(0));
    check("rst_if_pc", 64'(if_pc), 64'(0));
    check("rst_if_insn", 64'(if_insn), 64'(0));
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Randomised traffic at several memory latencies.
    rand_on = 1'b1;
    minw = 0; maxw = 0; repeat (1000) @(posedge clk);
    minw = 0; maxw = 1; repeat (1000) @(posedge clk);
    minw = 0; maxw = 3; repeat (1000) @(posedge clk);
    rand_on = 1'b0;

    // Fill with decode stalled: exactly DEPTH fetches, then one pop.
    @(posedge clk);
    dir_cpu_en = 1'b0; dir_ready = 1'b0; dir_br = 1'b1; dir_br_addr = 30'h0;
    repeat (8) @(posedge clk);
    minw = 0; maxw = 0;
    ack_count = 0;
    dir_cpu_en = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk); #2;
    check("fill_acks", 64'(ack_count), 64'(DEPTH));
    check("fill_count", 64'(fifo_count), 64'(DEPTH));
    check("fill_req", 64'(imem_req), 64'(0));
    @(posedge clk); dir_ready = 1'b1;
    @(posedge clk); dir_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #2;
      if (imem_req) found = 1'b1;
    end
    check("refill_req_seen", 64'(found), 64'(1));
    check("refill_addr", 64'(imem_addr), 64'(4));

    // Address wrap at the top of the word space.
    @(posedge clk);
    dir_br = 1'b1; dir_br_addr = 30'h3FFF_FFFF; dir_ready = 1'b1;
    popped.delete();
    repeat (12) @(posedge clk);
    check("wrap_pops", 64'(popped.size() >= 2), 64'(1));
    if (popped.size() >= 2) begin
      check("wrap_pc0", 64'(popped[0]), 64'(30'h3FFF_FFFF));
      check("wrap_pc1", 64'(popped[1]), 64'(30'h0));
    end

    // Asynchronous reset while a request is pending.
    @(posedge clk);
    minw = 3; maxw = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #2;
      if (imem_req && !imem_ack) found = 1'b1;
    end
    check("pending_req_seen", 64'(found), 64'(1));
    reset = 1'b0;
    #1;
    check("async_imem_req", 64'(imem_req), 64'(0));
    check("async_if_valid", 64'(if_valid), 64'(0));
    check("async_fifo_count", 64'(fifo_count), 64'(0));
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #2;
      if (imem_req) found = 1'b1;
    end
    check("post_rst_req_seen", 64'(found), 64'(1));
    check("post_rst_addr", 64'(imem_addr), 64'(RESET_PC));
    repeat (10) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_prefetch_buf.md
Name: if_prefetch_buf

Overview:
Instruction prefetch unit that sits directly upstream of the IF/ID register and decoder. It generates sequential word addresses and fetches instructions from instruction memory over a req/ack handshake. Fetched {pc, insn} pairs are buffered in a small FIFO and presented to decode over a valid/ready handshake. A taken branch (br_taken/br_addr from the decode stage) flushes the buffer and redirects fetch.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16
ADDR_W, 30, word address width (matches word address bus)
INSN_W, 32, instruction width
RESET_PC, 0, first fetch word address after reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
cpu_en  in  1  1 = new fetch requests may be issued
br_taken  in  1  redirect request from decode
br_addr  in  ADDR_W  redirect target word address
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  ADDR_W  fetch word address, stable while imem_req=1
imem_ack  in  1  request complete; imem_rd_data valid this cycle
imem_rd_data  in  INSN_W  returned instruction
if_valid  out  1  head entry valid
if_ready  in  1  decode accepts head
if_pc  out  ADDR_W  head entry pc
if_insn  out  INSN_W  head entry instruction
fifo_count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (reset=0, async) values:
  - fetch_pc=RESET_PC; FIFO empty; fifo_count=0; state=IDLE.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_insn=0.
- At most one request outstanding. Request slot is free when fifo_count + (state!=IDLE) < DEPTH.
- FSM states:
  - IDLE: imem_req=0. If cpu_en and a slot is free and !br_taken: go to REQ, latch imem_addr=fetch_pc.
  - REQ: imem_req=1, imem_addr held. On imem_ack without br_taken:
    - push {imem_addr, imem_rd_data}; fetch_pc += 1, wrapping mod 2^ADDR_W.
    - If cpu_en and a slot is still free (counting this push and any same-cycle pop), stay in REQ with imem_addr=fetch_pc+1 (back-to-back). Otherwise go to IDLE.
  - REQ with br_taken and no imem_ack: go to DROP.
  - REQ with br_taken and imem_ack in the same cycle: data discarded; go to IDLE.
  - DROP: imem_req=1, stale address held. On imem_ack: discard data, go to IDLE. br_taken in DROP only updates fetch_pc.
- br_taken (any state):
  - Same cycle: FIFO cleared; fetch_pc<=br_addr; if_valid=0 from the next cycle.
  - The earliest request to br_addr is issued the cycle after br_taken.
  - br_taken has priority over push and pop in the same cycle.
- Output: if_valid = (fifo_count != 0). if_pc/if_insn = head entry; they hold their last value when the FIFO is empty.
- Pop occurs when if_valid && if_ready && !br_taken.
- Push and pop in the same cycle leave fifo_count unchanged.
- Overflow is impossible by the slot rule. Underflow is impossible because a pop requires if_valid.
- Latency: imem_ack at cycle N -> if_valid=1 at cycle N+1 (non-bypass).
- cpu_en=0: no new requests. An outstanding request completes and its data is pushed. The FIFO continues draining.
- Back-to-back acks: a 0-wait memory sustains one fetch per cycle while the FIFO is not full.

Optional Feature:
IF_PREFETCH_BYPASS_EN:
- Defined: when the FIFO is empty, imem_ack=1, state=REQ and !br_taken, imem_rd_data and imem_addr are driven combinationally onto if_insn/if_pc with if_valid=1 in the same cycle.
  - If if_ready=1, the entry is consumed and not pushed.
  - If if_ready=0, the entry is pushed as normal.
- Undefined: if_valid is purely registered; there is always one cycle from ack to output.

Test Plan:
- Reset release, cpu_en=1, 0-wait memory returning insn=addr^32'hA5A5_0000, if_ready=1 -> imem_addr sequence 0,1,2,3...; if_pc 0,1,2 on consecutive cycles; first if_valid one cycle after first ack.
- if_ready=0, DEPTH=4, 0-wait memory -> exactly 4 acks accepted; fifo_count=4; imem_req=0. Then if_ready=1 for 1 cycle -> one pop; next request issued with imem_addr=4.
- Memory with 3-cycle ack latency; br_taken with br_addr=30'h100 in the second wait cycle -> that ack's data is not output; next imem_addr=30'h100; first if_pc after the branch = 30'h100.
- br_taken with br_addr=30'h40 in the same cycle as imem_ack and a pop, FIFO holding 2 entries -> fifo_count=0 next cycle; if_valid=0; next request address 30'h40.
- fetch_pc=30'h3FFF_FFFF, 0-wait memory -> next imem_addr=0 (wrap); if_pc order 3FFF_FFFF then 0.
- Async reset asserted mid-REQ (imem_req=1) between clock edges -> imem_req=0, if_valid=0, fifo_count=0 immediately, with no clock edge required; after release, first imem_addr=RESET_PC.
